uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command-frame controller that sits behind the UART receiver and sequences register-file accesses from the received byte stream. It parses write frames (0xAA, addr, data) and read frames (0xBB, addr), issues single-cycle register write/read strobes, and returns read data to the UART transmitter over a valid/busy handshake. It is the only master of the register-file port and the only requester of the transmitter.

## Interface
- ADDR_W, 4: register address width; the address byte's low ADDR_W bits are used and the upper bits are ignored.
- TIMEOUT, 1024: maximum clock cycles allowed between accepted frame bytes, and for the read-data wait. Must be ≥ 2.

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte, valid only with rx_valid
- rx_valid  input  1  one-cycle pulse per received byte
- rx_err  input  1  qualifies rx_valid; the byte had a parity or stop error
- reg_addr  output  ADDR_W  register address
- reg_wr_en  output  1  one-cycle write strobe
- reg_wr_data  output  8  write data
- reg_rd_en  output  1  one-cycle read strobe
- reg_rd_data  input  8  read data, sampled when reg_rd_valid is high
- reg_rd_valid  input  1  read-data-ready pulse
- tx_data  output  8  byte to transmit
- tx_valid  output  1  transmit request
- tx_busy  input  1  transmitter cannot accept a byte
- frame_err  output  1  one-cycle pulse on any frame error
- busy  output  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- A "good byte" is rx_valid=1 with rx_err=0. A "bad byte" is rx_valid=1 with rx_err=1.
- IDLE:
  - Good byte 0xAA → WR_ADDR.
  - Good byte 0xBB → RD_ADDR.
  - Any other good byte, or a bad byte → pulse frame_err and stay in IDLE.
- WR_ADDR: on a good byte, latch reg_addr from the byte's low ADDR_W bits → WR_DATA.
- WR_DATA: on a good byte, drive reg_wr_data with the byte, pulse reg_wr_en for one cycle → IDLE.
- RD_ADDR: on a good byte, latch reg_addr and pulse reg_rd_en for one cycle → RD_WAIT.
- RD_WAIT: on reg_rd_valid, latch reg_rd_data into tx_data and set tx_valid → TX_SEND.
- TX_SEND:
  - Hold tx_valid=1 and keep tx_data stable.
  - The transfer happens in the cycle where tx_valid=1 and tx_busy=0.
  - The next cycle, tx_valid=0 and the state → IDLE.
- Bad byte in WR_ADDR, WR_DATA or RD_ADDR → pulse frame_err → IDLE, with no strobe issued.
- Any byte (good or bad) arriving in RD_WAIT or TX_SEND is dropped and frame_err is pulsed. The state is unaffected.
- reg_rd_valid outside RD_WAIT is ignored.
- reg_addr and reg_wr_data hold their last values between accesses.

## Timing
- reg_wr_en is high in the cycle after the rx_valid of the data byte.
- reg_rd_en is high in the cycle after the rx_valid of the address byte.
- tx_valid rises in the cycle after the reg_rd_valid pulse.
- Minimum read turnaround with tx_busy=0: tx_valid is high for exactly 1 cycle.
- frame_err is high in the cycle after the offending event.
- A write frame with back-to-back bytes returns to IDLE in the cycle after the data byte, so a new 0xAA one cycle later is accepted.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0, and no pending strobe or tx_valid is emitted.

## Configuration
- Macro CMD_TIMEOUT_EN.
- When defined:
  - A cycle counter of $clog2(TIMEOUT) bits clears on entry to WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT, and on every accepted byte.
  - When the counter reaches TIMEOUT-1 in any of those states: pulse frame_err → IDLE, with no strobe or transmit.
  - If a good byte (or reg_rd_valid in RD_WAIT) arrives in the same cycle as expiry, the byte or data wins and the timeout is discarded.
  - TX_SEND never times out.
- When undefined: no counter exists, and the controller waits indefinitely in every state.

## Test plan
- Write frame: bytes 0xAA, 0x13, 0x5C with ADDR_W=4 → a single reg_wr_en pulse with reg_addr=0x3 and reg_wr_data=0x5C; frame_err stays 0.
- Read frame: bytes 0xBB, 0x07; reg_rd_valid with 0xA5 three cycles later; tx_busy high for 5 cycles → reg_rd_en pulses once with reg_addr=0x7; tx_valid is held with tx_data=0xA5 until tx_busy falls, then drops.
- Errors: unknown byte 0x42 in IDLE → frame_err pulse, state stays IDLE. Bad byte after 0xAA → frame_err, no reg_wr_en, and a following valid write frame completes normally.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT=16): 0xAA then silence → frame_err after 16 cycles; a late address byte is then treated as a command byte.
- Timeout race: the data byte arrives exactly at the expiry cycle → the write is issued and no frame_err is pulsed.
- Reset mid-frame: rst=1 for 1 cycle during RD_WAIT → busy=0, tx_valid=0, and a later reg_rd_valid is ignored.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Parses UART command frames (0xAA addr data / 0xBB addr), drives
//            register-file strobes and returns read data to the transmitter.
//            Define CMD_TIMEOUT_EN to add the inter-byte / read-wait timeout.
// Revision : 1.0
// ============================================================================
module uart_cmd_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    input  logic              reg_rd_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [7:0] C_CMD_WR = 8'hAA;
    localparam logic [7:0] C_CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_SEND = 3'd5
    } state_t;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("uart_cmd_ctrl: TIMEOUT must be at least 2");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wr_data_q, reg_wr_data_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic              reg_rd_en_q, reg_rd_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q;

    logic w_good;
    logic w_bad;
    logic w_expired;

    assign w_good = rx_valid & ~rx_err;
    assign w_bad  = rx_valid & rx_err;

`ifdef CMD_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_timed;

    assign w_timed   = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                       (state_q == ST_RD_ADDR) || (state_q == ST_RD_WAIT);
    assign w_expired = w_timed && (cnt_q == C_CNT_MAX);
    // Every accepted byte or read response changes state, so a state change
    // is the single restart condition for the counter.
    assign cnt_d     = (w_timed && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_en_d   = 1'b0;
        reg_rd_en_d   = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_good && (rx_data == C_CMD_WR)) begin
                    state_d = ST_WR_ADDR;
                end else if (w_good && (rx_data == C_CMD_RD)) begin
                    state_d = ST_RD_ADDR;
                end else if (rx_valid) begin
                    frame_err_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (w_good) begin
                    reg_addr_d = rx_data[ADDR_W-1:0];
                    state_d    = ST_WR_DATA;
                end else if (w_bad) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (w_good) begin
                    reg_wr_data_d = rx_data;
                    reg_wr_en_d   = 1'b1;
                    state_d       = ST_IDLE;
                end else if (w_bad) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (w_good) begin
                    reg_addr_d  = rx_data[ADDR_W-1:0];
                    reg_rd_en_d = 1'b1;
                    state_d     = ST_RD_WAIT;
                end else if (w_bad) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                frame_err_d = rx_valid;
                if (reg_rd_valid) begin
                    tx_data_d  = reg_rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                frame_err_d = rx_valid;
                if (tx_busy) begin
                    tx_valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte or read response in the expiry cycle moves the state and wins.
        if (w_expired && (state_d == state_q)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_rd_en_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_rd_en_q   <= reg_rd_en_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Vector table, corner sequences and random frames for
//            uart_cmd_ctrl. Timeout checks exist when CMD_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [7:0]        reg_wr_data;
    logic              reg_rd_en;
    logic [7:0]        reg_rd_data;
    logic              reg_rd_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_busy;
    logic              frame_err;
    logic              busy;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .frame_err(frame_err), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // {wr_en, rd_en, addr, wr_data, tx_valid, tx_data, frame_err, busy}
    logic [24:0] w_act;
    assign w_act = {reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
                    tx_valid, tx_data, frame_err, busy};

    typedef struct {
        logic        v;
        logic        e;
        logic [7:0]  d;
        logic        rv;
        logic [7:0]  rdd;
        logic        tb;
        logic [24:0] x;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [24:0] ex(logic wr, logic rd, logic [3:0] a, logic [7:0] wd,
                                       logic tv, logic [7:0] td, logic fe, logic bz);
        return {wr, rd, a, wd, tv, td, fe, bz};
    endfunction

    function automatic void add(logic v, logic e, logic [7:0] d, logic rv,
                                logic [7:0] rdd, logic tb, logic [24:0] x);
        vec_t t;
        t.v = v; t.e = e; t.d = d; t.rv = rv; t.rdd = rdd; t.tb = tb; t.x = x;
        tbl.push_back(t);
    endfunction

    task automatic drive(logic v, logic e, logic [7:0] d, logic rv, logic [7:0] rdd, logic tb);
        rx_valid     = v;
        rx_err       = e;
        rx_data      = d;
        reg_rd_valid = rv;
        reg_rd_data  = rdd;
        tx_busy      = tb;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [24:0] exp);
        checks++;
        if (w_act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, w_act, exp);
        end
    endtask

    // Transaction-level reference: each frame's effect on the register port,
    // transmitter and error counter is queued as the frame is generated.
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          exp_ferr  = 0;
    int          seen_ferr = 0;
    bit          mon_en    = 1'b0;
    logic [11:0] m_wr;
    logic [3:0]  m_rd;
    logic [7:0]  m_tx;

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_err) seen_ferr++;
            if (reg_wr_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL rand_wr: unexpected write addr=%h data=%h", reg_addr, reg_wr_data);
                end else begin
                    m_wr = exp_wr.pop_front();
                    if ({reg_addr, reg_wr_data} !== m_wr) begin
                        errors++;
                        $display("FAIL rand_wr: got %h expected %h", {reg_addr, reg_wr_data}, m_wr);
                    end
                end
            end
            if (reg_rd_en) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rand_rd: unexpected read addr=%h", reg_addr);
                end else begin
                    m_rd = exp_rd.pop_front();
                    if (reg_addr !== m_rd) begin
                        errors++;
                        $display("FAIL rand_rd: got %h expected %h", reg_addr, m_rd);
                    end
                end
            end
            if (tx_valid && !tx_busy) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL rand_tx: unexpected transfer data=%h", tx_data);
                end else begin
                    m_tx = exp_tx.pop_front();
                    if (tx_data !== m_tx) begin
                        errors++;
                        $display("FAIL rand_tx: got %h expected %h", tx_data, m_tx);
                    end
                end
            end
        end
    end

    task automatic gap(int n, bit allow_rv);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'($urandom), allow_rv && ($urandom_range(0, 3) == 0),
                  8'($urandom), 1'b0);
        end
    endtask

    task automatic maybe_stray(logic tb);
        if ($urandom_range(0, 2) == 0) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'($urandom), tb);
            exp_ferr++;
        end else begin
            drive(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom), tb);
        end
    endtask

    task automatic run_random(int frames);
        logic [7:0] a;
        logic [7:0] d;
        int         kind;
        for (int f = 0; f < frames; f++) begin
            kind = $urandom_range(0, 5);
            a    = 8'($urandom);
            d    = 8'($urandom);
            case (kind)
                0: begin
                    drive(1'b1, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b0);
                    gap($urandom_range(0, 3), 1'b1);
                    drive(1'b1, 1'b0, a, 1'b0, 8'h00, 1'b0);
                    gap($urandom_range(0, 3), 1'b1);
                    drive(1'b1, 1'b0, d, 1'b0, 8'h00, 1'b0);
                    exp_wr.push_back({a[3:0], d});
                end
                1: begin
                    drive(1'b1, 1'b0, 8'hBB, 1'b0, 8'h00, 1'b0);
                    gap($urandom_range(0, 2), 1'b1);
                    drive(1'b1, 1'b0, a, 1'b0, 8'h00, 1'b0);
                    exp_rd.push_back(a[3:0]);
                    for (int i = 0; i < $urandom_range(0, 3); i++) maybe_stray(1'b0);
                    drive(1'b0, 1'b0, 8'h00, 1'b1, d, 1'($urandom_range(0, 1)));
                    exp_tx.push_back(d);
                    for (int i = 0; i < $urandom_range(0, 3); i++) maybe_stray(1'b1);
                    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) begin
                        drive(1'b1, 1'b1, d, 1'b0, 8'h00, 1'b0);
                    end else begin
                        if (d == 8'hAA || d == 8'hBB) d = d ^ 8'h01;
                        drive(1'b1, 1'b0, d, 1'b0, 8'h00, 1'b0);
                    end
                    exp_ferr++;
                end
                3: begin
                    drive(1'b1, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b0);
                    if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, a, 1'b0, 8'h00, 1'b0);
                    drive(1'b1, 1'b1, d, 1'b0, 8'h00, 1'b0);
                    exp_ferr++;
                end
                4: begin
                    drive(1'b1, 1'b0, 8'hBB, 1'b0, 8'h00, 1'b0);
                    drive(1'b1, 1'b1, a, 1'b0, 8'h00, 1'b0);
                    exp_ferr++;
                end
                default: gap($urandom_range(1, 4), 1'b1);
            endcase
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2), 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        reg_rd_valid = 1'b0; reg_rd_data = 8'h00; tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0));
        rst = 1'b0;

        add(1, 0, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1));
        add(1, 0, 8'h13, 0, 8'h00, 0, ex(0, 0, 4'h3, 8'h00, 0, 8'h00, 0, 1));
        add(1, 0, 8'h5C, 0, 8'h00, 0, ex(1, 0, 4'h3, 8'h5C, 0, 8'h00, 0, 0));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h3, 8'h5C, 0, 8'h00, 0, 0));
        add(1, 0, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'h3, 8'h5C, 0, 8'h00, 0, 1));
        add(1, 0, 8'h2F, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h5C, 0, 8'h00, 0, 1));
        add(1, 0, 8'h11, 0, 8'h00, 0, ex(1, 0, 4'hF, 8'h11, 0, 8'h00, 0, 0));
        add(1, 0, 8'h42, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h11, 0, 8'h00, 1, 0));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h11, 0, 8'h00, 0, 0));
        add(1, 0, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h11, 0, 8'h00, 0, 1));
        add(1, 1, 8'h05, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h11, 0, 8'h00, 1, 0));
        add(1, 0, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'hF, 8'h11, 0, 8'h00, 0, 1));
        add(1, 0, 8'h01, 0, 8'h00, 0, ex(0, 0, 4'h1, 8'h11, 0, 8'h00, 0, 1));
        add(1, 0, 8'h99, 0, 8'h00, 0, ex(1, 0, 4'h1, 8'h99, 0, 8'h00, 0, 0));
        add(1, 0, 8'hBB, 0, 8'h00, 0, ex(0, 0, 4'h1, 8'h99, 0, 8'h00, 0, 1));
        add(1, 0, 8'h07, 0, 8'h00, 0, ex(0, 1, 4'h7, 8'h99, 0, 8'h00, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h7, 8'h99, 0, 8'h00, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h7, 8'h99, 0, 8'h00, 0, 1));
        add(0, 0, 8'h00, 1, 8'hA5, 1, ex(0, 0, 4'h7, 8'h99, 1, 8'hA5, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 1, ex(0, 0, 4'h7, 8'h99, 1, 8'hA5, 0, 1));
        add(1, 0, 8'h55, 0, 8'h00, 1, ex(0, 0, 4'h7, 8'h99, 1, 8'hA5, 1, 1));
        add(0, 0, 8'h00, 0, 8'h00, 1, ex(0, 0, 4'h7, 8'h99, 1, 8'hA5, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 1, ex(0, 0, 4'h7, 8'h99, 1, 8'hA5, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h7, 8'h99, 0, 8'hA5, 0, 0));
        add(0, 0, 8'h00, 1, 8'h3C, 0, ex(0, 0, 4'h7, 8'h99, 0, 8'hA5, 0, 0));
        add(1, 0, 8'hBB, 0, 8'h00, 0, ex(0, 0, 4'h7, 8'h99, 0, 8'hA5, 0, 1));
        add(1, 0, 8'h0A, 0, 8'h00, 0, ex(0, 1, 4'hA, 8'h99, 0, 8'hA5, 0, 1));
        add(0, 0, 8'h00, 1, 8'h66, 0, ex(0, 0, 4'hA, 8'h99, 1, 8'h66, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'hA, 8'h99, 0, 8'h66, 0, 0));
        add(1, 0, 8'hBB, 0, 8'h00, 0, ex(0, 0, 4'hA, 8'h99, 0, 8'h66, 0, 1));
        add(1, 1, 8'h0B, 0, 8'h00, 0, ex(0, 0, 4'hA, 8'h99, 0, 8'h66, 1, 0));
        add(1, 0, 8'hBB, 0, 8'h00, 0, ex(0, 0, 4'hA, 8'h99, 0, 8'h66, 0, 1));
        add(1, 0, 8'h02, 0, 8'h00, 0, ex(0, 1, 4'h2, 8'h99, 0, 8'h66, 0, 1));
        add(1, 0, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'h2, 8'h99, 0, 8'h66, 1, 1));
        add(0, 0, 8'h00, 1, 8'h77, 0, ex(0, 0, 4'h2, 8'h99, 1, 8'h77, 0, 1));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h2, 8'h99, 0, 8'h77, 0, 0));
        add(1, 1, 8'hAA, 0, 8'h00, 0, ex(0, 0, 4'h2, 8'h99, 0, 8'h77, 1, 0));
        add(0, 0, 8'h00, 0, 8'h00, 0, ex(0, 0, 4'h2, 8'h99, 0, 8'h77, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].e, tbl[i].d, tbl[i].rv, tbl[i].rdd, tbl[i].tb);
            check($sformatf("tbl[%0d]", i), tbl[i].x);
        end

        // Reset during RD_WAIT: nothing pending may leak out afterwards.
        drive(1, 0, 8'hBB, 0, 8'h00, 0);
        drive(1, 0, 8'h03, 0, 8'h00, 0);
        check("rst_pre", ex(0, 1, 4'h3, 8'h99, 0, 8'h77, 0, 1));
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("rst_mid", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0));
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 8'hEE, 0);
        check("rst_rdv_ignored", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0));
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("rst_after", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0));

`ifdef CMD_TIMEOUT_EN
        drive(1, 0, 8'hAA, 0, 8'h00, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("to_before", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1));
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("to_expire", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 1, 0));
        drive(1, 0, 8'h13, 0, 8'h00, 0);
        check("to_late_byte", ex(0, 0, 4'h0, 8'h00, 0, 8'h00, 1, 0));
        drive(1, 0, 8'hAA, 0, 8'h00, 0);
        drive(1, 0, 8'h05, 0, 8'h00, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 0, 8'h00, 0, 8'h00, 0);
        check("to_race_wait", ex(0, 0, 4'h5, 8'h00, 0, 8'h00, 0, 1));
        drive(1, 0, 8'h5A, 0, 8'h00, 0);
        check("to_race_win", ex(1, 0, 4'h5, 8'h5A, 0, 8'h00, 0, 0));
`endif

        mon_en = 1'b1;
        run_random(200);
        gap(3, 1'b0);
        mon_en = 1'b0;

        checks++;
        if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL rand_wr_pending: got %0d left expected 0", exp_wr.size());
        end
        checks++;
        if (exp_rd.size() != 0) begin
            errors++;
            $display("FAIL rand_rd_pending: got %0d left expected 0", exp_rd.size());
        end
        checks++;
        if (exp_tx.size() != 0) begin
            errors++;
            $display("FAIL rand_tx_pending: got %0d left expected 0", exp_tx.size());
        end
        checks++;
        if (seen_ferr != exp_ferr) begin
            errors++;
            $display("FAIL rand_frame_err: got %0d expected %0d", seen_ferr, exp_ferr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
